// File: rtl/stamp_pkg.sv
// Shared constants, slot state encoding and flat-bus slicing for the
// stamp/take pool and the write-back conveyor.
package stamp_pkg;

    localparam int NUM_REGS = 8;
    localparam int STAMP_W  = 3;
    localparam int TAKE_W   = 5;
    localparam int IDX_W    = $clog2(NUM_REGS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COUNT,
        S_DUE
    } slot_st_e;

    function automatic logic [STAMP_W-1:0] stamp_slice(
        input logic [NUM_REGS*STAMP_W-1:0] flat,
        input int unsigned                 i
    );
        return flat[i*STAMP_W +: STAMP_W];
    endfunction

    function automatic logic [TAKE_W-1:0] take_slice(
        input logic [NUM_REGS*TAKE_W-1:0] flat,
        input int unsigned                i
    );
        return flat[i*TAKE_W +: TAKE_W];
    endfunction

endpackage

// File: rtl/stamp_conveyor_if.sv
// Write-back ready/valid port of the conveyor.
interface stamp_conveyor_if;

    logic                          wb_valid;
    logic [stamp_pkg::IDX_W-1:0]   wb_reg;
    logic [stamp_pkg::TAKE_W-1:0]  wb_take;
    logic                          wb_ready;

    modport master (
        output wb_valid,
        output wb_reg,
        output wb_take,
        input  wb_ready
    );

    modport slave (
        input  wb_valid,
        input  wb_reg,
        input  wb_take,
        output wb_ready
    );

endinterface

// File: rtl/stamp_slot.sv
// One register slot: latency countdown, pending take and load collision.
module stamp_slot
    import stamp_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stamp_vld_i,
    input  logic [STAMP_W-1:0] stamp_i,
    input  logic              take_vld_i,
    input  logic [TAKE_W-1:0] take_i,
    input  logic              accept_i,
    output logic              busy_o,
    output logic              due_o,
    output logic [TAKE_W-1:0] take_val_o,
    output logic              coll_o
);

    slot_st_e           state_q, state_d;
    logic [STAMP_W-1:0] cnt_q, cnt_d;
    logic [TAKE_W-1:0]  take_q, take_d;
    logic               pend_q, pend_d;
    logic               load;
    logic               pend_nx;

    assign load    = stamp_vld_i | take_vld_i;
    assign pend_nx = take_vld_i | (pend_q & ~stamp_vld_i);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        take_d  = take_q;
        pend_d  = pend_q;
        unique case (1'b1)
            load: begin
                if (take_vld_i) take_d = take_i;
                pend_d = pend_nx;
                if (stamp_vld_i && stamp_i != '0) begin
                    state_d = S_COUNT;
                    cnt_d   = stamp_i;
                end else begin
                    state_d = pend_nx ? S_DUE : S_IDLE;
                    cnt_d   = '0;
                end
            end
            (!load && accept_i): begin
                state_d = S_IDLE;
                pend_d  = 1'b0;
            end
            (!load && !accept_i && state_q == S_COUNT): begin
                if (cnt_q > STAMP_W'(1)) begin
                    cnt_d = cnt_q - STAMP_W'(1);
                end else begin
                    state_d = pend_q ? S_DUE : S_IDLE;
                    cnt_d   = '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            take_q  <= '0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            take_q  <= take_d;
            pend_q  <= pend_d;
        end
    end

    assign busy_o     = (state_q != S_IDLE);
    assign due_o      = (state_q == S_DUE);
    assign take_val_o = take_q;
    // An accept on the same edge retires the old result, so it is no collision.
    assign coll_o     = load & (state_q != S_IDLE) & ~accept_i;

endmodule

// File: rtl/stamp_conveyor.sv
// Per-register write-back sequencer: slot countdowns plus a round-robin
// arbiter with a held grant driving a single ready/valid port.
module stamp_conveyor
    import stamp_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REGS*STAMP_W-1:0]  conveyor_stamp_flat,
    input  logic [NUM_REGS-1:0]          conveyor_stamp_in,
    input  logic [NUM_REGS*TAKE_W-1:0]   conveyor_take_flat,
    input  logic [NUM_REGS-1:0]          conveyor_take_in,
    output logic [NUM_REGS-1:0]          reg_busy,
    output logic                         collision,
    stamp_conveyor_if.master             wb
);

    logic [NUM_REGS-1:0] due;
    logic [NUM_REGS-1:0] coll;
    logic [NUM_REGS-1:0] acc_vec;
    logic [NUM_REGS-1:0] load_vec;
    logic [TAKE_W-1:0]   take_val [NUM_REGS];

    logic [IDX_W-1:0] rr_q, rr_d;
    logic             held_q, held_d;
    logic [IDX_W-1:0] held_idx_q, held_idx_d;
    logic             drop_q, drop_d;
    logic             coll_q;

    logic [IDX_W-1:0] pick;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] j;
    logic             found;
    logic             valid;
    logic             accept;
    logic             hit;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_slot
        stamp_slot u_slot (
            .clk        (clk),
            .rst_n      (rst_n),
            .stamp_vld_i(conveyor_stamp_in[g]),
            .stamp_i    (stamp_slice(conveyor_stamp_flat, g)),
            .take_vld_i (conveyor_take_in[g]),
            .take_i     (take_slice(conveyor_take_flat, g)),
            .accept_i   (acc_vec[g]),
            .busy_o     (reg_busy[g]),
            .due_o      (due[g]),
            .take_val_o (take_val[g]),
            .coll_o     (coll[g])
        );
    end

    always_comb begin
        pick  = rr_q;
        found = 1'b0;
        j     = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            j = rr_q + IDX_W'(k);
            if (!found && due[j]) begin
                pick  = j;
                found = 1'b1;
            end
        end
    end

    assign load_vec = conveyor_stamp_in | conveyor_take_in;
    assign idx      = held_q ? held_idx_q : pick;
    assign valid    = ~drop_q & (held_q | found);
    assign accept   = valid & wb.wb_ready;
    assign acc_vec  = accept ? (NUM_REGS'(1) << idx) : '0;
    assign hit      = valid & ~accept & load_vec[idx];

    always_comb begin
        rr_d       = rr_q;
        held_d     = held_q;
        held_idx_d = held_idx_q;
        drop_d     = hit;
        unique case (1'b1)
            accept: begin
                held_d = 1'b0;
                rr_d   = idx + IDX_W'(1);
            end
            hit:   held_d = 1'b0;
            (valid && !accept && !hit): begin
                held_d     = 1'b1;
                held_idx_d = idx;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q       <= '0;
            held_q     <= 1'b0;
            held_idx_q <= '0;
            drop_q     <= 1'b0;
            coll_q     <= 1'b0;
        end else begin
            rr_q       <= rr_d;
            held_q     <= held_d;
            held_idx_q <= held_idx_d;
            drop_q     <= drop_d;
            coll_q     <= coll_q | (|coll);
        end
    end

    assign collision   = coll_q;
    assign wb.wb_valid = valid;
    assign wb.wb_reg   = valid ? idx : '0;
    assign wb.wb_take  = valid ? take_val[idx] : '0;

endmodule

// File: tb/tb_stamp_conveyor.sv
// Directed vector bench for stamp_conveyor.
module tb_stamp_conveyor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [23:0] stamp_flat = '0;
    logic [7:0]  stamp_in = '0;
    logic [39:0] take_flat = '0;
    logic [7:0]  take_in = '0;
    logic [7:0]  reg_busy;
    logic        collision;

    int n_chk = 0;
    int n_fail = 0;

    stamp_conveyor_if wb_if ();

    stamp_conveyor dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .conveyor_stamp_flat(stamp_flat),
        .conveyor_stamp_in  (stamp_in),
        .conveyor_take_flat (take_flat),
        .conveyor_take_in   (take_in),
        .reg_busy           (reg_busy),
        .collision          (collision),
        .wb                 (wb_if.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] sf;
        logic [7:0]  si;
        logic [39:0] tf;
        logic [7:0]  ti;
        logic        rdy;
        logic [7:0]  busy;
        logic        val;
        logic [2:0]  rg;
        logic [4:0]  tk;
        logic        coll;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [23:0] S(input int i, input int n);
        return 24'(n) << (3 * i);
    endfunction

    function automatic logic [39:0] T(input int i, input int n);
        return 40'(n) << (5 * i);
    endfunction

    task automatic add(input logic [23:0] sf, input logic [7:0] si,
                       input logic [39:0] tf, input logic [7:0] ti,
                       input logic rdy, input logic [7:0] busy,
                       input logic val, input logic [2:0] rg,
                       input logic [4:0] tk, input logic coll);
        vec_t v;
        v.sf = sf; v.si = si; v.tf = tf; v.ti = ti; v.rdy = rdy;
        v.busy = busy; v.val = val; v.rg = rg; v.tk = tk; v.coll = coll;
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, got, exp, $time);
        end
    endtask

    task automatic chk_out(input string nm, input vec_t v);
        chk({nm, ".busy"},  64'(reg_busy),       64'(v.busy));
        chk({nm, ".valid"}, 64'(wb_if.wb_valid), 64'(v.val));
        chk({nm, ".reg"},   64'(wb_if.wb_reg),   64'(v.rg));
        chk({nm, ".take"},  64'(wb_if.wb_take),  64'(v.tk));
        chk({nm, ".coll"},  64'(collision),      64'(v.coll));
    endtask

    task automatic run(input string nm, input vec_t v);
        stamp_flat = v.sf; stamp_in = v.si;
        take_flat = v.tf; take_in = v.ti;
        wb_if.wb_ready = v.rdy;
        @(posedge clk);
        #1;
        stamp_flat = '0; stamp_in = '0;
        take_flat = '0; take_in = '0;
        chk_out(nm, v);
    endtask

    task automatic step(input string nm,
                        input logic [23:0] sf, input logic [7:0] si,
                        input logic [39:0] tf, input logic [7:0] ti,
                        input logic rdy, input logic [7:0] busy,
                        input logic val, input logic [2:0] rg,
                        input logic [4:0] tk, input logic coll);
        vec_t v;
        v.sf = sf; v.si = si; v.tf = tf; v.ti = ti; v.rdy = rdy;
        v.busy = busy; v.val = val; v.rg = rg; v.tk = tk; v.coll = coll;
        run(nm, v);
    endtask

    initial begin
        vec_t z;
        z.busy = 0; z.val = 0; z.rg = 0; z.tk = 0; z.coll = 0;
        z.sf = 0; z.si = 0; z.tf = 0; z.ti = 0; z.rdy = 0;
        wb_if.wb_ready = 1'b0;
        #12;
        chk_out("reset", z);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_out("post_reset", z);

        // b, e, h take-only: drained 1, 4, 7
        add(0, 0, T(1,5)|T(4,9)|T(7,30), 8'h92, 1, 8'h92, 1, 1, 5, 0);
        add(0, 0, 0, 0, 1, 8'h90, 1, 4, 9, 0);
        add(0, 0, 0, 0, 1, 8'h80, 1, 7, 30, 0);
        add(0, 0, 0, 0, 1, 8'h00, 0, 0, 0, 0);
        // rr pointer back at 0: slot 0 beats slot 7
        add(0, 0, T(0,3)|T(7,12), 8'h81, 1, 8'h81, 1, 0, 3, 0);
        add(0, 0, 0, 0, 1, 8'h80, 1, 7, 12, 0);
        add(0, 0, 0, 0, 1, 8'h00, 0, 0, 0, 0);
        // slot c: stamp 3 + take 17
        add(S(2,3), 8'h04, T(2,17), 8'h04, 1, 8'h04, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 8'h04, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 8'h04, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 8'h04, 1, 2, 17, 0);
        add(0, 0, 0, 0, 1, 8'h00, 0, 0, 0, 0);
        // slot a: stamp 2, no take
        add(S(0,2), 8'h01, 0, 0, 1, 8'h01, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 8'h01, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 8'h00, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 8'h00, 0, 0, 0, 0);

        for (int i = 0; i < tbl.size(); i++)
            run($sformatf("vec%0d", i), tbl[i]);

        // ready low 5 cycles with slots 3 and 6 due
        step("hold_ld", 0, 0, T(3,11)|T(6,22), 8'h48, 0,
             8'h48, 1, 3, 11, 0);
        for (int i = 0; i < 5; i++)
            step($sformatf("hold%0d", i), 0, 0, 0, 0, 0,
                 8'h48, 1, 3, 11, 0);
        step("hold_acc", 0, 0, 0, 0, 1, 8'h40, 1, 6, 22, 0);
        step("hold_end", 0, 0, 0, 0, 1, 8'h00, 0, 0, 0, 0);

        // reload at own accept edge: no collision
        step("acc_ld0", 0, 0, T(5,7), 8'h20, 1, 8'h20, 1, 5, 7, 0);
        step("acc_ld1", S(5,2), 8'h20, T(5,13), 8'h20, 1,
             8'h20, 0, 0, 0, 0);
        step("acc_ld2", 0, 0, 0, 0, 1, 8'h20, 0, 0, 0, 0);
        step("acc_ld3", 0, 0, 0, 0, 1, 8'h20, 1, 5, 13, 0);
        step("acc_ld4", 0, 0, 0, 0, 1, 8'h00, 0, 0, 0, 0);

        // collision on slot d
        step("coll0", S(3,4), 8'h08, 0, 0, 1, 8'h08, 0, 0, 0, 0);
        step("coll1", 0, 0, 0, 0, 1, 8'h08, 0, 0, 0, 0);
        step("coll2", S(3,1), 8'h08, 0, 0, 1, 8'h08, 0, 0, 0, 1);
        step("coll3", 0, 0, 0, 0, 1, 8'h00, 0, 0, 0, 1);
        step("coll4", 0, 0, 0, 0, 1, 8'h00, 0, 0, 0, 1);

        // overwrite of granted slot drops the offer one cycle
        step("drop0", 0, 0, T(6,21), 8'h40, 0, 8'h40, 1, 6, 21, 1);
        step("drop1", 0, 0, T(6,2)|T(1,4), 8'h42, 0,
             8'h42, 0, 0, 0, 1);
        step("drop2", 0, 0, 0, 0, 0, 8'h42, 1, 6, 2, 1);
        step("drop3", 0, 0, 0, 0, 1, 8'h02, 1, 1, 4, 1);
        step("drop4", 0, 0, 0, 0, 1, 8'h00, 0, 0, 0, 1);

        // asynchronous reset while all slots count
        step("rst_ld", 24'hB6DB6D, 8'hFF, {8{5'd9}}, 8'hFF, 1,
             8'hFF, 0, 0, 0, 1);
        step("rst_cnt", 0, 0, 0, 0, 1, 8'hFF, 0, 0, 0, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("async_rst", z);
        #3;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++)
            step($sformatf("after_rst%0d", i), 0, 0, 0, 0, 1,
                 8'h00, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/stamp_conveyor.md
# stamp_conveyor

Per-register write-back sequencer that sits directly downstream of the stamp/take pool. Each cycle it accepts the merged per-register stamp (3-bit latency count) and take (5-bit result-position select) requests for registers a–h. It counts each stamped register down to completion and marks it busy meanwhile. When a register's count expires with a take pending, it issues the write-back over a single ready/valid port, arbitrating round-robin between registers that are due.

## Interface
Parameters:
- NUM_REGS, 8, register slots a–h (index 0 = a)
- STAMP_W, 3, stamp (latency count) width
- TAKE_W, 5, take (result position) width

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- conveyor_stamp_flat  in  24  slot i stamp at [3i+2:3i]
- conveyor_stamp_in  in  8  slot i stamp valid
- conveyor_take_flat  in  40  slot i take at [5i+4:5i]
- conveyor_take_in  in  8  slot i take valid
- reg_busy  out  8  slot i not IDLE
- wb_valid  out  1  write-back offered
- wb_reg  out  3  register index of offered write-back
- wb_take  out  5  result position of offered write-back
- wb_ready  in  1  consumer accepts write-back this cycle
- collision  out  1  sticky: a load hit a non-idle slot

## Operation
- Slot state per register: IDLE, COUNT(c), c in 1..7, DUE. Each slot also holds take_val[4:0] and a take_pend flag.
- A load on slot i is either stamp_in[i] or take_in[i] sampled at a clock edge:
  - stamp_in with value N ≥ 1 → COUNT(N).
  - stamp_in with N = 0 → DUE if a take is pending after the load, else IDLE.
  - take_in without stamp_in → treated as a stamp of 0, so the slot goes DUE.
  - take_in latches take_val and sets take_pend.
  - stamp_in without take_in clears take_pend.
- COUNT(c) with c > 1 → COUNT(c−1). COUNT(1) → DUE if take_pend, else IDLE with no write-back.
- DUE holds until its write-back is accepted (wb_valid && wb_ready with wb_reg = i). It then goes IDLE and clears take_pend.
- Load to a non-IDLE slot: the new load overwrites the slot state and sets collision. Exception: if the same edge accepts that slot's write-back, the accept completes, the load proceeds and collision is not set.
- Arbitration: round-robin over DUE slots, searching upward from rr_ptr with wrap 7→0.
  - The grant is latched whenever wb_valid rises and is held, with wb_reg and wb_take, until accepted.
  - On accept, rr_ptr = granted index + 1 mod 8.
  - A load overwriting the granted slot drops the offer. wb_valid goes low for one cycle, then arbitration restarts.
- wb_take is the granted slot's take_val.
- reg_busy[i] = (state ≠ IDLE).
- Counter arithmetic: unsigned 3-bit; no wrap, since the decrement only happens for c ≥ 1.

## Timing
- Reset (rst_n low, asynchronous): all slots IDLE, take_pend = 0, take_val = 0, rr_ptr = 0, grant cleared, collision = 0. Resulting outputs: reg_busy = 0, wb_valid = 0, wb_reg = 0, wb_take = 0.
- Mid-operation reset drops every pending count and write-back without emitting it.
- A load sampled at edge E0 with stamp N:
  - reg_busy is high after E0.
  - The slot is DUE after edge E_N; for N = 0 that is after E0.
  - wb_valid is high in the same cycle the slot is DUE, if the slot wins arbitration.
- All outputs are registered-state driven; wb_valid, wb_reg and wb_take have no combinational path from any input. wb_ready is sampled only at edges.
- Accept takes one edge: the slot is IDLE after the accepting edge. The next DUE slot is offered in the following cycle, so there are no bubbles while any slot is DUE.
- Throughput: one write-back per cycle.

## Structure
- Shared package stamp_pkg holds NUM_REGS, STAMP_W, TAKE_W, the slot state enum (IDLE/COUNT/DUE) and flat-bus slice helper functions. The pool and this block both import it.
- Sub-module stamp_slot: one per register, generated 8×. It contains the state/counter, take_val and take_pend, and has load, accept and collision-detect ports.
- The round-robin arbiter and grant latch stay inline in stamp_conveyor.

## Test plan
- Slot c: stamp 3 plus take 17 at E0, wb_ready = 1 → reg_busy[2] high after E0; wb_valid high after E3 with wb_reg = 2, wb_take = 17; reg_busy[2] low after E4.
- Slot a: stamp 2, no take → busy for 2 cycles, then IDLE; wb_valid never asserts.
- Slots b, e, h: take-only loads at the same edge, wb_ready = 1 → write-backs in order 1, 4, 7 on three consecutive cycles; rr_ptr = 0 after.
- wb_ready low for 5 cycles while slots 3 and 6 are DUE → wb_reg = 3 and wb_take held stable for all 5 cycles; slot 6 is offered the cycle after ready rises.
- Stamp 4 on slot d, then stamp 1 on d two cycles later → collision = 1 (sticky); slot d is DUE/IDLE after 1 more edge. A load on a slot at its own accept edge → collision stays 0.
- Reset asserted asynchronously while slots 0–7 are counting → all outputs are zero immediately, with no write-back after release.
